fib_capture_fifo: RTL

//  Downstream consumer of the fibonacci counter output. Samples the WIDTH-bit value bus (driven from a

---
 rtl/fib_capture_pkg.sv | 23 ++
 rtl/fib_sync_fifo.sv | 57 +++++
 rtl/fib_capture_fifo.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fib_capture_pkg.sv
// Shared register map and field positions for the fibonacci capture FIFO.
// Optional timestamp support is selected with FIB_CAPTURE_TIMESTAMP_EN.
package fib_capture_pkg;

    localparam int unsigned ADR_W           = 5;
    localparam int unsigned DATA_W          = 32;

    localparam logic [ADR_W-1:0] ADR_DATA   = 5'h00;
    localparam logic [ADR_W-1:0] ADR_STATUS = 5'h04;
    localparam logic [ADR_W-1:0] ADR_CTRL   = 5'h08;
    localparam logic [ADR_W-1:0] ADR_DROPS  = 5'h0C;
    localparam logic [ADR_W-1:0] ADR_TSTAMP = 5'h10;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_THRESH_LSB = 8;
    localparam int unsigned CTRL_THRESH_W   = 8;
    localparam int unsigned CTRL_FLUSH_BIT  = 31;
    localparam int unsigned DROPS_CLR_BIT   = 0;

    localparam int unsigned DROPS_W         = 16;
    localparam logic [DROPS_W-1:0] DROPS_MAX = 16'hFFFF;

endpackage

// File: rtl/fib_sync_fifo.sv
// Single-clock FIFO with flush; pushes when full and pops when empty are ignored.
module fib_sync_fifo #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic                        i_flush,
    input  logic [WIDTH-1:0]            i_data,
    output logic [WIDTH-1:0]            o_head_c,
    output logic                        o_full_c,
    output logic                        o_empty_c,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push    = i_push & ~o_full_c;
    assign w_pop     = i_pop & ~o_empty_c;
    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_head_c  = r_mem[r_rptr];
    assign o_count   = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/fib_capture_fifo.sv
// Captures each new stable fibonacci value into a FIFO drained over Wishbone.
// Define FIB_CAPTURE_TIMESTAMP_EN to store an accept-time cycle stamp per entry.
module fib_capture_fifo
    import fib_capture_pkg::*;
#(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 16
) (
    input  logic             wb_clk_i,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] value_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [4:0]       wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef FIB_CAPTURE_TIMESTAMP_EN
    localparam int unsigned FW = WIDTH + 32;
`else
    localparam int unsigned FW = WIDTH;
`endif

    logic [WIDTH-1:0]         r_s1;
    logic [WIDTH-1:0]         r_s2;
    logic [WIDTH-1:0]         r_last;
    logic                     r_en;
    logic [CTRL_THRESH_W-1:0] r_thresh;
    logic                     r_ovf;
    logic [DROPS_W-1:0]       r_drops;
    logic                     r_ack;
    logic [DATA_W-1:0]        r_dat;
    logic                     r_irq;

    logic              w_access;
    logic              w_wr;
    logic              w_rd;
    logic [ADR_W-1:0]  w_adr;
    logic              w_ctrl_wr;
    logic              w_flush;
    logic              w_drops_clr;
    logic              w_accept;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [FW-1:0]     w_head;
    logic [FW-1:0]     w_push_data;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    assign w_access    = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr        = w_access & wbs_we_i & (wbs_sel_i == 4'hF);
    assign w_rd        = w_access & ~wbs_we_i;
    assign w_adr       = {wbs_adr_i[4:2], 2'b00};
    assign w_ctrl_wr   = w_wr & (w_adr == ADR_CTRL);
    assign w_flush     = w_ctrl_wr & wbs_dat_i[CTRL_FLUSH_BIT];
    assign w_drops_clr = w_wr & (w_adr == ADR_DROPS) & wbs_dat_i[DROPS_CLR_BIT];
    assign w_accept    = r_en & (r_s1 == r_s2) & (r_s2 != r_last);
    assign w_push      = w_accept & ~w_flush & ~w_full;
    assign w_drop      = w_accept & ~w_flush & w_full;
    assign w_pop       = w_rd & (w_adr == ADR_DATA) & ~w_empty;
    assign w_unused    = ^{wbs_adr_i[1:0], wbs_dat_i[30:16], wbs_dat_i[7:1]};

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_irq;

`ifdef FIB_CAPTURE_TIMESTAMP_EN
    logic [31:0] r_cycle;
    logic [31:0] r_tstamp;

    assign w_push_data = {r_cycle, r_s2};

    // Free-running stamp; the popped entry's stamp is held for a later TSTAMP read.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle  <= '0;
            r_tstamp <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_pop) r_tstamp <= w_head[FW-1:WIDTH];
        end
    end
`else
    assign w_push_data = r_s2;
`endif

    fib_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst_n     (reset_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .i_data    (w_push_data),
        .o_head_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_count   (w_count)
    );

    // Two-stage sampler; last tracks the most recently accepted value, dropped or not.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_last <= '0;
        end else begin
            r_s1 <= value_i;
            r_s2 <= r_s1;
            if (w_accept) r_last <= r_s2;
        end
    end

    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_en     <= 1'b0;
            r_thresh <= '0;
            r_ovf    <= 1'b0;
            r_drops  <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_en     <= wbs_dat_i[CTRL_EN_BIT];
                r_thresh <= wbs_dat_i[CTRL_THRESH_LSB +: CTRL_THRESH_W];
            end
            if (w_drops_clr) begin
                r_ovf   <= 1'b0;
                r_drops <= '0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drops != DROPS_MAX) r_drops <= r_drops + 16'd1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            ADR_DATA:   if (!w_empty) w_rdata = 32'(w_head[WIDTH-1:0]);
            ADR_STATUS: w_rdata = {21'b0, r_ovf, w_full, w_empty, 8'(w_count)};
            ADR_CTRL: begin
                w_rdata[CTRL_EN_BIT] = r_en;
                w_rdata[CTRL_THRESH_LSB +: CTRL_THRESH_W] = r_thresh;
            end
            ADR_DROPS:  w_rdata[DROPS_W-1:0] = r_drops;
`ifdef FIB_CAPTURE_TIMESTAMP_EN
            ADR_TSTAMP: w_rdata = r_tstamp;
`else
            ADR_TSTAMP: w_rdata = '0;
`endif
            default:    w_rdata = '0;
        endcase
    end

    // Ack follows an access by one cycle and blocks a new access while high.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ack <= w_access;
            r_dat <= w_rd ? w_rdata : '0;
            r_irq <= r_en & (((16'(w_count) >= 16'(r_thresh)) & (r_thresh != '0)) | r_ovf);
        end
    end

endmodule
